// File: rtl/seq_pkg.sv
// seq_pkg: next-PC select encodings shared by the sequencer and its bench
package seq_pkg;
  localparam logic [2:0] SRC_INC    = 3'b000;
  localparam logic [2:0] SRC_JUMP   = 3'b001;
  localparam logic [2:0] SRC_RET    = 3'b010;
  localparam logic [2:0] SRC_BRANCH = 3'b011;
  localparam logic [2:0] SRC_CALL   = 3'b100;
endpackage

// File: rtl/call_stack.sv
// call_stack: bounded LIFO of return addresses
// push/pop are ignored when full/empty respectively; top is the newest entry,
// depth the occupancy (0..DEPTH); full/empty decode depth.
module call_stack #(
  parameter int W     = 12,
  parameter int DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [W-1:0]                   data_in,
  output logic [W-1:0]                   top,
  output logic [$clog2(DEPTH+1)-1:0]     depth,
  output logic                           full,
  output logic                           empty
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [DW-1:0] sp_q, sp_d;
  logic          do_push, do_pop;
  always_comb begin
    full    = sp_q == DW'(DEPTH);
    empty   = sp_q == '0;
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    sp_d    = do_push ? sp_q + 1'b1 : do_pop ? sp_q - 1'b1 : sp_q;
    top     = mem_q[AW'(sp_q - 1'b1)];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) sp_q <= '0;
    else     sp_q <= sp_d;
  // storage is not reset; only entries below sp are ever read
  always_ff @(posedge clk)
    if (do_push) mem_q[AW'(sp_q)] <= data_in;
  assign depth = sp_q;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register with inc/jump/branch/call/return and return stack
// In: clk, rst (async high), en (0 = stall), pc_src, target, offset,
//     branch_taken, err_clear. Out: pc, pc_plus1, depth, overflow, underflow.
module pc_sequencer
  import seq_pkg::*;
#(
  parameter int              PC_W     = 12,
  parameter int              OFF_W    = 8,
  parameter int              DEPTH    = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [2:0]                 pc_src,
  input  logic [PC_W-1:0]            target,
  input  logic [OFF_W-1:0]           offset,
  input  logic                       branch_taken,
  input  logic                       err_clear,
  output logic [PC_W-1:0]            pc,
  output logic [PC_W-1:0]            pc_plus1,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       overflow,
  output logic                       underflow
);
  logic [PC_W-1:0] pc_q, pc_d, top, br_pc;
  logic            overflow_q, overflow_d, underflow_q, underflow_d;
  logic            push, pop, full, empty;
  call_stack #(.W(PC_W), .DEPTH(DEPTH)) u_stack (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .data_in(pc_plus1),
    .top(top), .depth(depth), .full(full), .empty(empty)
  );
  always_comb begin
    pc_plus1    = pc_q + 1'b1;
    br_pc       = pc_plus1 + PC_W'($signed(offset));
    push        = en & (pc_src == SRC_CALL);
    pop         = en & (pc_src == SRC_RET);
    pc_d        = !en                                      ? pc_q   :
                  (pc_src == SRC_JUMP || pc_src == SRC_CALL) ? target :
                  (pop && !empty)                          ? top    :
                  (pc_src == SRC_BRANCH && branch_taken)   ? br_pc  : pc_plus1;
    // a new error on this edge beats a simultaneous clear
    overflow_d  = (push & full) | (overflow_q & ~err_clear);
    underflow_d = (pop & empty) | (underflow_q & ~err_clear);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc_q        <= RESET_PC;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  assign pc        = pc_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
endmodule
